// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Sequences one round of baccarat. It deals two cards each to the player and
// the banker, decides on the player's third card, applies the banker's drawing
// table, and then shows the result until the next reset.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | one-cycle pause after reset, all outputs low
//   DEAL_P1  | load player card 1
//   DEAL_D1  | load dealer card 1
//   DEAL_P2  | load player card 2
//   DEAL_D2  | load dealer card 2
//   CHECK    | look for naturals and decide whether the player draws
//   DRAW_P3  | load player card 3
//   BANKER   | apply the banker table using the player's third card
//   DRAW_D3  | load dealer card 3
//   DONE     | round over, lights show the result; held until reset
//
// Ports
//   slow_clock        in   clock, rising edge active
//   resetb            in   synchronous reset, active high
//   pscore[3:0]       in   player hand score (0-9) from the datapath
//   dscore[3:0]       in   dealer hand score (0-9) from the datapath
//   pcard3[3:0]       in   player third-card rank (1-13, 0 = none)
//   load_pcard1..3    out  one-cycle load strobes for the player card registers
//   load_dcard1..3    out  one-cycle load strobes for the dealer card registers
//   player_win_light  out  player wins, or tie
//   dealer_win_light  out  dealer wins, or tie
// -----------------------------------------------------------------------------
module round_controller (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        CHECK   = 4'd5,
        DRAW_P3 = 4'd6,
        BANKER  = 4'd7,
        DRAW_D3 = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       in_done;
    logic       natural;
    logic       banker_draws;
    logic [3:0] p3_value;

    // Face cards and tens count as zero. Ranks beyond 13 are not dealt, so
    // they simply fall into the same bucket.
    assign p3_value = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

    // Scores above 9 are not range-checked; they just never count as naturals.
    assign natural = (pscore == 4'd8) || (pscore == 4'd9) ||
                     (dscore == 4'd8) || (dscore == 4'd9);

    // Banker drawing table, indexed by the banker's two-card score and the
    // value of the player's third card.
    always_comb begin
        banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (p3_value != 4'd8);
            4'd4:             banker_draws = (p3_value >= 4'd2) && (p3_value <= 4'd7);
            4'd5:             banker_draws = (p3_value >= 4'd4) && (p3_value <= 4'd7);
            4'd6:             banker_draws = (p3_value >= 4'd6) && (p3_value <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = DEAL_P1;
            DEAL_P1: next_state = DEAL_D1;
            DEAL_D1: next_state = DEAL_P2;
            DEAL_P2: next_state = DEAL_D2;
            DEAL_D2: next_state = CHECK;
            CHECK: begin
                if (natural) begin
                    next_state = DONE;
                end else if (pscore <= 4'd5) begin
                    next_state = DRAW_P3;
                end else if ((pscore <= 4'd7) && (dscore <= 4'd5)) begin
                    // Player stands; banker draws on 0-5 without a table lookup.
                    next_state = DRAW_D3;
                end else begin
                    next_state = DONE;
                end
            end
            DRAW_P3: next_state = BANKER;
            BANKER:  next_state = banker_draws ? DRAW_D3 : DONE;
            DRAW_D3: next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode so each one is high
    // for exactly the cycle its state is current, with no glitch paths.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state       <= IDLE;
            in_done     <= 1'b0;
            load_pcard1 <= 1'b0;
            load_pcard2 <= 1'b0;
            load_pcard3 <= 1'b0;
            load_dcard1 <= 1'b0;
            load_dcard2 <= 1'b0;
            load_dcard3 <= 1'b0;
        end else begin
            state       <= next_state;
            in_done     <= (next_state == DONE);
            load_pcard1 <= (next_state == DEAL_P1);
            load_pcard2 <= (next_state == DEAL_P2);
            load_pcard3 <= (next_state == DRAW_P3);
            load_dcard1 <= (next_state == DEAL_D1);
            load_dcard2 <= (next_state == DEAL_D2);
            load_dcard3 <= (next_state == DRAW_D3);
        end
    end

    // Lights track the live scores while in DONE, so a late datapath update
    // after the final load is still reflected. A tie lights both.
    assign player_win_light = in_done && (pscore >= dscore);
    assign dealer_win_light = in_done && (dscore >= pscore);

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    int compared   = 0;
    int mismatched = 0;
    int round_no   = 0;

    round_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    always #5 slow_clock = ~slow_clock;

    // Strobe vector order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_P1   = 6'b100000;
    localparam logic [5:0] S_D1   = 6'b010000;
    localparam logic [5:0] S_P2   = 6'b001000;
    localparam logic [5:0] S_D2   = 6'b000100;
    localparam logic [5:0] S_P3   = 6'b000010;
    localparam logic [5:0] S_D3   = 6'b000001;

    function automatic logic [7:0] observed();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                load_pcard3, load_dcard3, player_win_light, dealer_win_light};
    endfunction

    // Reference rules of the game, written as plain card arithmetic.
    function automatic bit is_natural(int s);
        return (s == 8) || (s == 9);
    endfunction

    function automatic int card_value(int rank);
        return (rank >= 1 && rank <= 9) ? rank : 0;
    endfunction

    // Banker with 4, 5 or 6 draws when the card value lies between
    // 2*(score-3) and 7.
    function automatic bit banker_rule(int d, int v);
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d >= 4 && d <= 6) return (v >= 2 * (d - 3)) && (v <= 7);
        return 1'b0;
    endfunction

    function automatic logic [1:0] lights_for(int p, int d);
        if (p > d) return 2'b10;
        if (d > p) return 2'b01;
        return 2'b11;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Plays one round from a reset edge. p0/d0 are the scores seen at CHECK
    // and BANKER; c3 is the third-card rank presented only while BANKER is
    // current (random junk otherwise). Once DONE is reached, pf/df are driven
    // for three cycles and random scores afterwards. A nonzero abort_at ends
    // the round early after that cycle so the caller can reset mid-deal.
    task automatic run_round(int p0, int d0, int c3, int pf, int df,
                             int hold, int abort_at);
        logic [5:0] exp_q[$];
        int bank_idx;
        int done_idx;
        int cur_p;
        int cur_d;
        logic [7:0] exp;
        round_no++;
        exp_q = '{S_NONE, S_P1, S_D1, S_P2, S_D2, S_NONE};
        bank_idx = -1;
        if (is_natural(p0) || is_natural(d0)) begin
        end else if (p0 <= 5) begin
            exp_q.push_back(S_P3);
            exp_q.push_back(S_NONE);
            bank_idx = exp_q.size() - 1;
            if (banker_rule(d0, card_value(c3))) exp_q.push_back(S_D3);
        end else if (p0 <= 7 && d0 <= 5) begin
            exp_q.push_back(S_D3);
        end
        done_idx = exp_q.size();

        cur_p  = p0;
        cur_d  = d0;
        resetb = 1'b1;
        pscore = 4'(cur_p);
        dscore = 4'(cur_d);
        pcard3 = 4'($urandom_range(0, 13));
        @(posedge slow_clock);
        #1;
        check($sformatf("r%0d reset", round_no), observed(), 8'h00);
        resetb = 1'b0;

        for (int k = 1; k < done_idx + hold; k++) begin
            pcard3 = (k - 1 == bank_idx) ? 4'(c3) : 4'($urandom_range(0, 13));
            if (k > done_idx) begin
                if (k - done_idx <= 3) begin
                    cur_p = pf;
                    cur_d = df;
                end else begin
                    cur_p = $urandom_range(0, 15);
                    cur_d = $urandom_range(0, 15);
                end
                pscore = 4'(cur_p);
                dscore = 4'(cur_d);
            end
            @(posedge slow_clock);
            #1;
            if (k < done_idx) exp = {exp_q[k], 2'b00};
            else              exp = {S_NONE, lights_for(cur_p, cur_d)};
            check($sformatf("r%0d cyc%0d", round_no, k), observed(), exp);
            if (k == abort_at) return;
        end
    endtask

    initial begin
        // Natural for the player: straight to DONE on the 6th cycle.
        run_round(8, 3, 0, 8, 3, 4, 0);
        // Player draws a 4, banker on 5 draws; player ends on 8 vs 2.
        run_round(4, 5, 4, 8, 2, 4, 0);
        // Player draws a queen, banker on 6 stands; dealer wins 3 vs 6.
        run_round(3, 6, 12, 3, 6, 4, 0);
        // Player stands on 7, banker on 4 draws; tie at 7.
        run_round(7, 4, 0, 7, 7, 4, 0);
        // Banker on 3 stands only on an 8; banker on 7 never draws.
        run_round(2, 3, 8, 5, 5, 2, 0);
        run_round(2, 3, 9, 5, 5, 2, 0);
        run_round(1, 7, 6, 1, 7, 2, 0);
        // Dealer natural, player stands with banker on 6, out-of-range dscore.
        run_round(0, 9, 3, 0, 9, 2, 0);
        run_round(6, 6, 5, 6, 6, 2, 0);
        run_round(5, 12, 3, 5, 12, 2, 0);
        // Reset while DEAL_P2 is current, then a round that idles in DONE.
        run_round(2, 2, 5, 0, 0, 8, 3);
        run_round(2, 2, 5, 4, 1, 25, 0);

        for (int i = 0; i < 60; i++) begin
            run_round($urandom_range(0, 9), $urandom_range(0, 15),
                      $urandom_range(0, 13), $urandom_range(0, 9),
                      $urandom_range(0, 9), $urandom_range(1, 6),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
